// File: rtl/clock_div_pkg.sv
// Shared encodings for the programmable clock divider.
// Contents: mode_e (value reported on the mode output), state_e (RUN/PAUSED
// FSM encoding), selector width, and a helper that maps the active divisor to
// its run-time mode code.
package clock_div_pkg;

    localparam int unsigned SEL_W  = 8;
    localparam int unsigned MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_FAST   = 2'd0,
        MODE_SLOW   = 2'd1,
        MODE_PAUSED = 2'd2
    } mode_e;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_e;

    // Mode code reported while running, from the active-divisor select bit.
    function automatic mode_e run_mode(input logic slow);
        return slow ? MODE_SLOW : MODE_FAST;
    endfunction

endpackage

// File: rtl/clock_div_prog_if.sv
// Control/status bundle of the programmable clock divider.
// slave  (divider side): selector, key_n, pause, step in; clkout, tick, mode out.
// master (driver side) : the mirror image.
interface clock_div_prog_if;
    import clock_div_pkg::*;

    logic [SEL_W-1:0]  selector;
    logic              key_n;
    logic              pause;
    logic              step;
    logic              clkout;
    logic              tick;
    logic [MODE_W-1:0] mode;

    modport master (
        output selector, key_n, pause, step,
        input  clkout, tick, mode
    );

    modport slave (
        input  selector, key_n, pause, step,
        output clkout, tick, mode
    );

endinterface

// File: rtl/clock_div_prog_div_counter.sv
// Half-period cycle counter with terminal-count compare.
// Ports: clkin/rst (sync, active-high), clear (force counter to 0),
// enable (count this cycle), limit (terminal count = divisor - 1),
// wrap (combinational: enabled and at terminal count, counter returns to 0).
module div_counter #(
    parameter int unsigned CNT_W = 26
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] limit,
    output logic             wrap
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Compare against divisor-1 so a divisor of 2^CNT_W still fits CNT_W bits.
    always_comb begin
        wrap  = enable && (cnt_q == limit);
        cnt_d = cnt_q;
        if (clear || wrap) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/clock_div_prog.sv
// Programmable clock divider: clkout toggles every FAST_DIV or SLOW_DIV clkin
// cycles; can be paused and single-stepped one half-period at a time.
// Ports: clkin, rst (sync, active-high); bus (slave): selector, key_n, pause,
// step in; clkout (registered divided clock), tick (one-cycle pulse with each
// clkout toggle), mode (0 FAST, 1 SLOW, 2 PAUSED) out.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned FAST_DIV = 10000,
    parameter int unsigned SLOW_DIV = 50000000,
    parameter int unsigned SEL_SLOW = 48
) (
    input  logic            clkin,
    input  logic            rst,
    clock_div_prog_if.slave bus
);

    localparam logic [CNT_W-1:0] FAST_LIM = CNT_W'(FAST_DIV - 1);
    localparam logic [CNT_W-1:0] SLOW_LIM = CNT_W'(SLOW_DIV - 1);

    state_e state_q, state_d;
    logic   slow_q, slow_d;      // active divisor: 1 = SLOW_DIV
    logic   clkout_q, clkout_d;
    logic   tick_q, tick_d;
    mode_e  mode_q, mode_d;

    logic             req_slow_c;
    logic             step_c;
    logic             cnt_en_c;
    logic             wrap_c;
    logic [CNT_W-1:0] limit_c;

    assign req_slow_c = (bus.selector == SEL_W'(SEL_SLOW)) || !bus.key_n;
    // Step only counts when already paused and still holding pause.
    assign step_c     = (state_q == ST_PAUSED) && bus.pause && bus.step;
    assign cnt_en_c   = (state_q == ST_RUN);
    assign limit_c    = slow_q ? SLOW_LIM : FAST_LIM;

    div_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clkin  (clkin),
        .rst    (rst),
        .clear  (step_c),
        .enable (cnt_en_c),
        .limit  (limit_c),
        .wrap   (wrap_c)
    );

    // Next state: a wrap or a step ends the half-period and is the only
    // point where the requested divisor becomes active.
    always_comb begin
        state_d  = bus.pause ? ST_PAUSED : ST_RUN;
        slow_d   = slow_q;
        clkout_d = clkout_q;
        tick_d   = 1'b0;
        if (wrap_c || step_c) begin
            clkout_d = ~clkout_q;
            tick_d   = 1'b1;
            slow_d   = req_slow_c;
        end
        mode_d = (state_d == ST_PAUSED) ? MODE_PAUSED : run_mode(slow_d);
    end

    always_ff @(posedge clkin) begin
        if (rst) begin
            state_q  <= ST_RUN;
            slow_q   <= 1'b0;
            clkout_q <= 1'b0;
            tick_q   <= 1'b0;
            mode_q   <= MODE_FAST;
        end else begin
            state_q  <= state_d;
            slow_q   <= slow_d;
            clkout_q <= clkout_d;
            tick_q   <= tick_d;
            mode_q   <= mode_d;
        end
    end

    assign bus.clkout = clkout_q;
    assign bus.tick   = tick_q;
    assign bus.mode   = MODE_W'(mode_q);

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog (FAST_DIV=4, SLOW_DIV=10, CNT_W=8).
module tb_clock_div_prog;

    localparam int unsigned CNT_W = 8;
    localparam int unsigned FAST  = 4;
    localparam int unsigned SLOW  = 10;
    localparam int unsigned SEL   = 48;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clock_div_prog_if bus ();

    clock_div_prog #(
        .CNT_W    (CNT_W),
        .FAST_DIV (FAST),
        .SLOW_DIV (SLOW),
        .SEL_SLOW (SEL)
    ) dut (
        .clkin (clk),
        .rst   (rst),
        .bus   (bus)
    );

    typedef struct packed {
        logic       clkout;
        logic       tick;
        logic [1:0] mode;
        logic [7:0] cnt;
    } obs_t;

    typedef struct {
        bit         rst;
        logic [7:0] sel;
        bit         key_n;
        bit         pause;
        bit         step;
        int         n;
        int         exp_ticks;
        logic [1:0] exp_mode;
    } vec_t;

    obs_t sb[$];
    vec_t tbl[$];

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;
    int seg_ticks;

    // Reference model state
    int m_cnt    = 0;
    int m_div    = FAST;
    bit m_clk    = 1'b0;
    bit m_paused = 1'b0;
    bit m_tick   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h (cycle %0d)", name, act, exp, ncyc);
        end
    endtask

    // Advance the model by one clkin edge using the currently driven inputs.
    task automatic model_step();
        int req;
        if (rst) begin
            m_cnt = 0; m_clk = 1'b0; m_paused = 1'b0; m_div = FAST; m_tick = 1'b0;
        end else begin
            req    = (bus.selector == 8'(SEL) || !bus.key_n) ? SLOW : FAST;
            m_tick = 1'b0;
            if (!m_paused) begin
                if (m_cnt == m_div - 1) begin
                    m_cnt = 0; m_clk = ~m_clk; m_tick = 1'b1; m_div = req;
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end else if (bus.pause && bus.step) begin
                m_cnt = 0; m_clk = ~m_clk; m_tick = 1'b1; m_div = req;
            end
            m_paused = bus.pause;
        end
    endtask

    // One clock: push expected observation, then pop and compare after the edge.
    task automatic cyc();
        obs_t e, a;
        logic [1:0] m_mode;
        model_step();
        m_mode = m_paused ? 2'd2 : ((m_div == SLOW) ? 2'd1 : 2'd0);
        sb.push_back({m_clk, m_tick, m_mode, 8'(m_cnt)});
        @(posedge clk);
        #1;
        ncyc++;
        a = {bus.clkout, bus.tick, bus.mode, dut.u_cnt.cnt_q};
        e = sb.pop_front();
        check("cycle_obs", 32'(a), 32'(e));
        if (bus.tick === 1'b1) seg_ticks++;
    endtask

    // Run until a tick is seen; n = cycles taken. Bounded by budget.
    task automatic wait_tick(input string name, input int budget, output int n);
        n = 0;
        do begin
            cyc();
            n++;
        end while (bus.tick !== 1'b1 && n < budget);
        check({name, "_seen"}, 32'(bus.tick), 32'd1);
    endtask

    task automatic drive(input bit r, input logic [7:0] s, input bit k, input bit p, input bit st);
        rst = r; bus.selector = s; bus.key_n = k; bus.pause = p; bus.step = st;
    endtask

    initial begin
        int n;
        logic held_clk;

        drive(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);

        //            rst sel   key pau stp  n  ticks mode
        tbl.push_back('{1, 8'd0,  1, 0, 0,  2, 0, 2'd0});  // reset
        tbl.push_back('{0, 8'd0,  1, 0, 0, 12, 3, 2'd0});  // free run FAST
        tbl.push_back('{0, 8'd0,  1, 0, 0,  1, 0, 2'd0});
        tbl.push_back('{0, 8'd48, 1, 0, 0,  3, 1, 2'd1});  // SLOW req after wrap
        tbl.push_back('{0, 8'd48, 1, 0, 0, 20, 2, 2'd1});
        tbl.push_back('{0, 8'd0,  1, 0, 0, 10, 1, 2'd0});  // back to FAST at wrap
        tbl.push_back('{0, 8'd0,  1, 0, 0,  1, 0, 2'd0});
        tbl.push_back('{0, 8'd0,  0, 0, 0,  2, 0, 2'd0});  // key_n blip reverts
        tbl.push_back('{0, 8'd0,  1, 0, 0,  9, 3, 2'd0});
        tbl.push_back('{0, 8'd0,  1, 0, 0,  2, 0, 2'd0});  // counter=2
        tbl.push_back('{0, 8'd0,  1, 1, 0, 20, 0, 2'd2});  // paused
        tbl.push_back('{0, 8'd0,  1, 0, 0,  2, 1, 2'd0});  // resume
        tbl.push_back('{0, 8'd0,  1, 0, 0,  1, 0, 2'd0});
        tbl.push_back('{0, 8'd0,  1, 1, 1,  1, 0, 2'd2});  // step on RUN->PAUSED ignored
        tbl.push_back('{0, 8'd0,  1, 1, 0,  2, 0, 2'd2});
        tbl.push_back('{0, 8'd0,  1, 1, 1,  1, 1, 2'd2});  // step 1
        tbl.push_back('{0, 8'd0,  1, 1, 0,  2, 0, 2'd2});
        tbl.push_back('{0, 8'd0,  1, 1, 1,  1, 1, 2'd2});  // step 2
        tbl.push_back('{0, 8'd0,  1, 1, 0,  2, 0, 2'd2});
        tbl.push_back('{0, 8'd0,  1, 1, 1,  1, 1, 2'd2});  // step 3
        tbl.push_back('{0, 8'd0,  1, 1, 0,  2, 0, 2'd2});
        tbl.push_back('{0, 8'd48, 1, 1, 1,  1, 1, 2'd2});  // step loads SLOW
        tbl.push_back('{0, 8'd48, 1, 0, 0,  1, 0, 2'd1});
        tbl.push_back('{0, 8'd0,  1, 0, 0, 10, 1, 2'd0});
        tbl.push_back('{0, 8'd0,  1, 0, 1,  2, 0, 2'd0});  // step in RUN ignored
        tbl.push_back('{0, 8'd0,  1, 0, 0,  2, 1, 2'd0});
        tbl.push_back('{0, 8'd48, 1, 0, 0,  4, 1, 2'd1});
        tbl.push_back('{0, 8'd48, 1, 0, 0,  7, 0, 2'd1});  // counter=7 in SLOW
        tbl.push_back('{1, 8'd48, 1, 0, 0,  1, 0, 2'd0});  // reset mid half-period
        tbl.push_back('{0, 8'd0,  1, 0, 0,  4, 1, 2'd0});
        tbl.push_back('{0, 8'd0,  1, 1, 0,  3, 0, 2'd2});
        tbl.push_back('{1, 8'd0,  1, 1, 0,  1, 0, 2'd0});  // reset while paused
        tbl.push_back('{0, 8'd0,  1, 0, 0,  4, 1, 2'd0});

        foreach (tbl[i]) begin
            drive(tbl[i].rst, tbl[i].sel, tbl[i].key_n, tbl[i].pause, tbl[i].step);
            seg_ticks = 0;
            repeat (tbl[i].n) cyc();
            check($sformatf("row%0d_ticks", i), 32'(seg_ticks), 32'(tbl[i].exp_ticks));
            check($sformatf("row%0d_mode", i), 32'(bus.mode), 32'(tbl[i].exp_mode));
        end

        // Hand sequence: reset state and half-period lengths across a SLOW request.
        drive(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        repeat (2) cyc();
        check("rst_clkout", 32'(bus.clkout), 32'd0);
        check("rst_tick", 32'(bus.tick), 32'd0);
        check("rst_mode", 32'(bus.mode), 32'd0);
        check("rst_cnt", 32'(dut.u_cnt.cnt_q), 32'd0);
        rst = 1'b0;
        wait_tick("first_half", 40, n);
        check("first_half_len", 32'(n), 32'(FAST));
        wait_tick("fast_half", 40, n);
        check("fast_half_len", 32'(n), 32'(FAST));
        cyc();
        bus.selector = 8'(SEL);
        wait_tick("pending_half", 40, n);
        check("pending_half_len", 32'(n + 1), 32'(FAST));
        check("slow_mode", 32'(bus.mode), 32'd1);
        wait_tick("slow_half1", 40, n);
        check("slow_half1_len", 32'(n), 32'(SLOW));
        wait_tick("slow_half2", 40, n);
        check("slow_half2_len", 32'(n), 32'(SLOW));
        bus.selector = 8'd0;
        wait_tick("slow_tail", 40, n);
        check("slow_tail_len", 32'(n), 32'(SLOW));
        check("fast_mode", 32'(bus.mode), 32'd0);
        wait_tick("fast_again", 40, n);
        check("fast_again_len", 32'(n), 32'(FAST));

        // Hand sequence: pause at counter=2 freezes output, resume finishes the half-period.
        repeat (2) cyc();
        check("pre_pause_cnt", 32'(dut.u_cnt.cnt_q), 32'd2);
        held_clk = bus.clkout;
        bus.pause = 1'b1;
        seg_ticks = 0;
        repeat (20) cyc();
        check("pause_ticks", 32'(seg_ticks), 32'd0);
        check("pause_clkout", 32'(bus.clkout), 32'(held_clk));
        check("pause_mode", 32'(bus.mode), 32'd2);
        bus.pause = 1'b0;
        wait_tick("resume", 40, n);
        check("resume_len", 32'(n), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
